// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback stage and register file.
// Holds the writeback source encodings, the destination field position and default widths.
package wb_regfile_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_INSTR_W = 19;
  localparam int DEF_NREGS   = 8;

  localparam int DST_MSB = 12;
  localparam int DST_LSB = 10;

  typedef enum logic [1:0] {
    WB_SEL_ALU   = 2'b00,
    WB_SEL_MEM   = 2'b01,
    WB_SEL_SHIFT = 2'b10,
    WB_SEL_NONE  = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/wb_regfile_mux.sv
// Writeback source select and write qualification (module wb_mux).
// A write is valid only with enable set, a non-reserved select and a non-zero destination.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int AW      = DST_MSB - DST_LSB + 1
) (
  input  logic [DATA_W-1:0]  wb_mem_data,
  input  logic [DATA_W-1:0]  wb_alu_out,
  input  logic [DATA_W-1:0]  wb_shift_out,
  input  logic [INSTR_W-1:0] wb_instruction,
  input  logic [1:0]         wb_reg_write_mux,
  input  logic               wb_reg_write,
  output logic [DATA_W-1:0]  wb_data,
  output logic [AW-1:0]      wb_dst,
  output logic               wb_valid
);

  wb_sel_e sel;
  logic    unusedInstrBits;

  assign sel    = wb_sel_e'(wb_reg_write_mux);
  assign wb_dst = wb_instruction[DST_MSB:DST_LSB];

  // Only the destination field of the instruction matters here.
  assign unusedInstrBits = ^{wb_instruction[INSTR_W-1:DST_MSB+1], wb_instruction[DST_LSB-1:0]};

  always_comb begin
    wb_data = '0;
    case (sel)
      WB_SEL_ALU:   wb_data = wb_alu_out;
      WB_SEL_MEM:   wb_data = wb_mem_data;
      WB_SEL_SHIFT: wb_data = wb_shift_out;
      default:      wb_data = '0;
    endcase
  end

  assign wb_valid = wb_reg_write & (sel != WB_SEL_NONE) & (wb_dst != '0);

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus 8x8 register file with two combinational read ports and prev_* forwarding taps.
// Define REGFILE_BYPASS_EN to make a same-cycle read of the destination return the value being written.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int NREGS   = DEF_NREGS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        wb_mem_data,
  input  logic [DATA_W-1:0]        wb_alu_out,
  input  logic [DATA_W-1:0]        wb_shift_out,
  input  logic [INSTR_W-1:0]       wb_instruction,
  input  logic [1:0]               wb_reg_write_mux,
  input  logic                     wb_reg_write,
  input  logic [$clog2(NREGS)-1:0] rd_addr_a,
  input  logic [$clog2(NREGS)-1:0] rd_addr_b,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic [DATA_W-1:0]        rd_data_b,
  output logic [DATA_W-1:0]        wb_data,
  output logic [$clog2(NREGS)-1:0] wb_dst,
  output logic                     wb_valid,
  output logic [DATA_W-1:0]        prev_wb_data,
  output logic [$clog2(NREGS)-1:0] prev_wb_dst,
  output logic                     prev_wb_valid
);

  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] prev_wb_data_q;
  logic [AW-1:0]     prev_wb_dst_q;
  logic              prev_wb_valid_q;

  wb_mux #(
    .DATA_W  (DATA_W),
    .INSTR_W (INSTR_W),
    .AW      (AW)
  ) u_wb_mux (
    .wb_mem_data      (wb_mem_data),
    .wb_alu_out       (wb_alu_out),
    .wb_shift_out     (wb_shift_out),
    .wb_instruction   (wb_instruction),
    .wb_reg_write_mux (wb_reg_write_mux),
    .wb_reg_write     (wb_reg_write),
    .wb_data          (wb_data),
    .wb_dst           (wb_dst),
    .wb_valid         (wb_valid)
  );

  // wb_valid already excludes R0, so entry 0 keeps its reset value forever.
  always_comb begin
    regs_d = regs_q;
    if (wb_valid) regs_d[wb_dst] = wb_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q          <= '{default: '0};
      prev_wb_data_q  <= '0;
      prev_wb_dst_q   <= '0;
      prev_wb_valid_q <= 1'b0;
    end else begin
      regs_q          <= regs_d;
      prev_wb_data_q  <= wb_data;
      prev_wb_dst_q   <= wb_dst;
      prev_wb_valid_q <= wb_valid;
    end
  end

  // The bypass is gated by reset so reads stay at zero while reset is held.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != '0) rd_data_a = regs_q[rd_addr_a];
    if (rd_addr_b != '0) rd_data_b = regs_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (reset && wb_valid && (rd_addr_a == wb_dst)) rd_data_a = wb_data;
    if (reset && wb_valid && (rd_addr_b == wb_dst)) rd_data_b = wb_data;
`endif
  end

  assign prev_wb_data  = prev_wb_data_q;
  assign prev_wb_dst   = prev_wb_dst_q;
  assign prev_wb_valid = prev_wb_valid_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations follow REGFILE_BYPASS_EN when defined.
module tb_wb_regfile;

  logic       clk;
  logic       resetN;
  logic [7:0] memData, aluOut, shiftOut;
  logic [18:0] instr;
  logic [1:0] selMux;
  logic       regWrite;
  logic [2:0] addrA, addrB;
  logic [7:0] dataA, dataB, wbData, prevData;
  logic [2:0] wbDst, prevDst;
  logic       wbValid, prevValid;

  int assertCount = 0;
  int failCount   = 0;

  wb_regfile dut (
    .clk              (clk),
    .reset            (resetN),
    .wb_mem_data      (memData),
    .wb_alu_out       (aluOut),
    .wb_shift_out     (shiftOut),
    .wb_instruction   (instr),
    .wb_reg_write_mux (selMux),
    .wb_reg_write     (regWrite),
    .rd_addr_a        (addrA),
    .rd_addr_b        (addrB),
    .rd_data_a        (dataA),
    .rd_data_b        (dataB),
    .wb_data          (wbData),
    .wb_dst           (wbDst),
    .wb_valid         (wbValid),
    .prev_wb_data     (prevData),
    .prev_wb_dst      (prevDst),
    .prev_wb_valid    (prevValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Surrounding instruction bits are non-zero so a wrong field slice shows up.
  task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] alu, input logic [7:0] mem,
                               input logic [7:0] shf, input logic [2:0] dst, input logic we);
    selMux   = sel;
    aluOut   = alu;
    memData  = mem;
    shiftOut = shf;
    instr    = {6'b101010, dst, 10'h155};
    regWrite = we;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    addrA = 3'd3;
    addrB = 3'd5;
    resetN = 1'b0;
    #12;
    assertCount++;
    if (dataA !== 8'h00 || dataB !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_reads: a=%h b=%h expected 00 00", dataA, dataB);
    end
    assertCount++;
    if (prevData !== 8'h00 || prevDst !== 3'd0 || prevValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_prev: data=%h dst=%0d valid=%b expected 00 0 0", prevData, prevDst, prevValid);
    end
    @(negedge clk);
    resetN = 1'b1;
    stepEdge();
  endtask

  task automatic test_write_read();
    applyStimulus(2'b00, 8'h5A, 8'hEE, 8'hDD, 3'd3, 1'b1);
    #1;
    assertCount++;
    if (wbData !== 8'h5A || wbDst !== 3'd3 || wbValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL alu_select: data=%h dst=%0d valid=%b expected 5a 3 1", wbData, wbDst, wbValid);
    end
    stepEdge();
    idle();
    addrA = 3'd3;
    addrB = 3'd0;
    #1;
    assertCount++;
    if (dataA !== 8'h5A) begin
      failCount++;
      $display("[TB] FAIL read_r3: got %h expected 5a", dataA);
    end
    assertCount++;
    if (dataB !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL read_r0: got %h expected 00", dataB);
    end
  endtask

  task automatic test_r0_write();
    applyStimulus(2'b01, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b1);
    #1;
    assertCount++;
    if (wbValid !== 1'b0 || wbData !== 8'hFF) begin
      failCount++;
      $display("[TB] FAIL r0_valid: valid=%b data=%h expected 0 ff", wbValid, wbData);
    end
    stepEdge();
    idle();
    addrA = 3'd0;
    #1;
    assertCount++;
    if (dataA !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL r0_read: got %h expected 00", dataA);
    end
  endtask

  task automatic test_reserved();
    applyStimulus(2'b00, 8'h11, 8'h00, 8'h00, 3'd5, 1'b1);
    stepEdge();
    applyStimulus(2'b11, 8'h99, 8'h98, 8'h97, 3'd5, 1'b1);
    addrA = 3'd5;
    #1;
    assertCount++;
    if (wbValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reserved_valid: got %b expected 0", wbValid);
    end
    stepEdge();
    idle();
    #1;
    assertCount++;
    if (dataA !== 8'h11) begin
      failCount++;
      $display("[TB] FAIL reserved_r5: got %h expected 11", dataA);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] expectBefore;
`ifdef REGFILE_BYPASS_EN
    expectBefore = 8'h3C;
`else
    expectBefore = 8'h00;
`endif
    applyStimulus(2'b10, 8'h01, 8'h02, 8'h3C, 3'd6, 1'b1);
    addrA = 3'd6;
    addrB = 3'd6;
    #1;
    assertCount++;
    if (dataA !== expectBefore || dataB !== expectBefore) begin
      failCount++;
      $display("[TB] FAIL same_cycle_r6: a=%h b=%h expected %h", dataA, dataB, expectBefore);
    end
    stepEdge();
    idle();
    #1;
    assertCount++;
    if (dataA !== 8'h3C) begin
      failCount++;
      $display("[TB] FAIL after_edge_r6: got %h expected 3c", dataA);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(2'b00, 8'h01, 8'h00, 8'h00, 3'd1, 1'b1);
    stepEdge();
    applyStimulus(2'b01, 8'h00, 8'h02, 8'h00, 3'd2, 1'b1);
    #1;
    assertCount++;
    if (prevDst !== 3'd1 || prevData !== 8'h01 || prevValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL prev_cycle2: dst=%0d data=%h valid=%b expected 1 01 1", prevDst, prevData, prevValid);
    end
    stepEdge();
    idle();
    addrA = 3'd1;
    addrB = 3'd2;
    #1;
    assertCount++;
    if (prevDst !== 3'd2 || prevData !== 8'h02 || prevValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL prev_cycle3: dst=%0d data=%h valid=%b expected 2 02 1", prevDst, prevData, prevValid);
    end
    assertCount++;
    if (dataA !== 8'h01 || dataB !== 8'h02) begin
      failCount++;
      $display("[TB] FAIL b2b_reads: a=%h b=%h expected 01 02", dataA, dataB);
    end
  endtask

  task automatic test_mid_reset();
    applyStimulus(2'b00, 8'h77, 8'h00, 8'h00, 3'd4, 1'b1);
    stepEdge();
    applyStimulus(2'b01, 8'h00, 8'h99, 8'h00, 3'd7, 1'b1);
    addrA = 3'd4;
    addrB = 3'd7;
    #1;
    assertCount++;
    if (dataA !== 8'h77) begin
      failCount++;
      $display("[TB] FAIL r4_loaded: got %h expected 77", dataA);
    end
    #1;
    resetN = 1'b0;
    #1;
    assertCount++;
    if (dataA !== 8'h00 || dataB !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL midreset_reads: a=%h b=%h expected 00 00", dataA, dataB);
    end
    assertCount++;
    if (prevData !== 8'h00 || prevDst !== 3'd0 || prevValid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_prev: data=%h dst=%0d valid=%b expected 00 0 0", prevData, prevDst, prevValid);
    end
    assertCount++;
    if (wbValid !== 1'b1 || wbData !== 8'h99 || wbDst !== 3'd7) begin
      failCount++;
      $display("[TB] FAIL midreset_wb: valid=%b data=%h dst=%0d expected 1 99 7", wbValid, wbData, wbDst);
    end
    stepEdge();
    assertCount++;
    if (dataB !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL write_in_reset: r7=%h expected 00", dataB);
    end
    @(negedge clk);
    resetN = 1'b1;
    stepEdge();
    idle();
    #1;
    assertCount++;
    if (dataB !== 8'h99 || dataA !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL post_reset_write: r7=%h r4=%h expected 99 00", dataB, dataA);
    end
  endtask

  initial begin
    resetN = 1'b1;
    addrA  = 3'd0;
    addrB  = 3'd0;
    idle();
    test_reset();
    test_write_read();
    test_r0_write();
    test_reserved();
    test_bypass();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and register file for the 8-bit pipeline, at the consuming end of the MEM/WB pipeline register. Selects the writeback value from the memory, ALU and shifter results, writes it into an 8-entry x 8-bit register file, and serves two asynchronous read ports to the decode stage. Also exports the current and previous writeback for the forwarding unit.

## Interface
Parameters:
- DATA_W, 8, register and datapath width
- INSTR_W, 19, instruction word width
- NREGS, 8, register count; address width is log2(NREGS) = 3

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- wb_mem_data  in  8  memory read data from MEM/WB
- wb_alu_out  in  8  ALU result from MEM/WB
- wb_shift_out  in  8  shifter result from MEM/WB
- wb_instruction  in  19  instruction from MEM/WB; destination field is bits [12:10]
- wb_reg_write_mux  in  2  writeback source select
- wb_reg_write  in  1  write enable
- rd_addr_a, rd_addr_b  in  3 each  decode-stage read addresses
- rd_data_a, rd_data_b  out  8 each  read data
- wb_data  out  8  selected writeback value (combinational)
- wb_dst  out  3  destination register (combinational)
- wb_valid  out  1  write actually performed this cycle
- prev_wb_data  out  8  wb_data registered one cycle
- prev_wb_dst  out  3  wb_dst registered one cycle
- prev_wb_valid  out  1  wb_valid registered one cycle

## Operation
- Source select: 00 = ALU, 01 = memory, 10 = shifter, 11 = reserved. A reserved select suppresses the write.
- wb_valid = wb_reg_write & (select != 11) & (wb_dst != 0).
- R0 reads as 0, is never written, and writes to it are dropped silently (wb_valid = 0).
- On a rising edge with wb_valid = 1, regs[wb_dst] <= wb_data. At most one write per cycle.
- Reads are combinational on rd_addr_*. Address 0 always returns 0.
- Previous-write registers (prev_*) capture wb_data, wb_dst and wb_valid on every rising edge, whatever their values.
- Reset (reset = 0, asynchronous): all registers go to 0, and prev_wb_data, prev_wb_dst and prev_wb_valid go to 0. wb_data, wb_dst and wb_valid follow their inputs combinationally; rd_data_* return 0. If reset asserts mid-cycle, a pending write is lost. A write first takes effect on the first rising edge after reset deasserts.

## Timing
- Write latency: one edge. The value is visible on the read ports in the following cycle, or in the same cycle when the bypass is compiled in.
- The prev_* outputs lag wb_* by exactly one cycle.
- Read ports have zero latency: a purely combinational path from rd_addr_*, wb_* and the stored registers.
- Simultaneous reads of the same address on both ports return the same value.

## Configuration
- REGFILE_BYPASS_EN defined: when wb_valid = 1 and rd_addr_x == wb_dst, rd_data_x = wb_data in the same cycle (write-through).
- REGFILE_BYPASS_EN undefined: rd_data_x returns the stored value. The new value appears only after the edge, and the hazard unit must stall one extra cycle.

## Structure
- Shared package holds:
  - WB_SEL_ALU / WB_SEL_MEM / WB_SEL_SHIFT / WB_SEL_NONE encodings
  - DST_MSB = 12, DST_LSB = 10
  - DATA_W, INSTR_W and NREGS defaults
- One sub-module, wb_mux: the combinational source select plus the wb_valid qualification. The register array, bypass and prev_* registers stay in wb_regfile.

## Test plan
- Write R3 = 0x5A: select 00, wb_alu_out = 0x5A, dst = 3, reg_write = 1, one edge. Then rd_addr_a = 3 -> 0x5A; rd_addr_b = 0 -> 0x00.
- Write to R0: select 01, wb_mem_data = 0xFF, dst = 0. Expect wb_valid = 0 and a later read of R0 = 0x00.
- Reserved select 11 with reg_write = 1 and dst = 5. Expect wb_valid = 0 and R5 unchanged from its prior value 0x11.
- Same-cycle read of the destination being written: write R6 = 0x3C via shifter while rd_addr_a = 6. Expect 0x3C before the edge with REGFILE_BYPASS_EN, and the old value (0x00) without it.
- Back-to-back writes R1 = 0x01 then R2 = 0x02. In cycle 2, prev_wb_dst = 1, prev_wb_data = 0x01, prev_wb_valid = 1.
- Assert reset mid-cycle after loading R4 = 0x77. All reads return 0x00 and prev_* read 0 immediately, without a clock edge; the first write after deassertion succeeds.
